// File: rtl/osc_pkg.sv
`default_nettype none
// ============================================================================
// osc_pkg : shared state encoding and trigger constants for the OSI capture path
// Rev 1.0
// ============================================================================
package osc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } osc_state_e;

  localparam logic EDGE_RISE   = 1'b0;
  localparam logic EDGE_FALL   = 1'b1;
  localparam logic TRIG_AUTO   = 1'b0;
  localparam logic TRIG_NORMAL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/osc_edge_det.sv
`default_nettype none
// ============================================================================
// osc_edge_det : previous-sample register and level-crossing comparators
// Rev 1.0
// ============================================================================
module osc_edge_det
  import osc_pkg::*;
(
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       enable_i,
  input  logic       sample_i,
  input  logic [7:0] data_i,
  input  logic [7:0] level_i,
  input  logic       edge_i,
  output logic       hit_o
);

  logic [7:0] prev_q;
  logic       valid_q;
  logic       w_rise;
  logic       w_fall;

  // prev only becomes trustworthy after the first sample seen while enabled
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      prev_q  <= '0;
      valid_q <= 1'b0;
    end else if (!enable_i) begin
      valid_q <= 1'b0;
    end else if (sample_i) begin
      prev_q  <= data_i;
      valid_q <= 1'b1;
    end
  end

  always_comb begin
    w_rise = (prev_q < level_i) && (data_i >= level_i);
    w_fall = (prev_q >= level_i) && (data_i < level_i);
    hit_o  = valid_q && sample_i && ((edge_i == EDGE_FALL) ? w_fall : w_rise);
  end

endmodule
`default_nettype wire

// File: rtl/osc_trig_ctrl.sv
`default_nettype none
// ============================================================================
// osc_trig_ctrl : circular-buffer capture sequencer with pre-trigger and auto mode
// Rev 1.0
// ============================================================================
module osc_trig_ctrl
  import osc_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int AUTO_TO = 4096
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              run,
  input  logic              sample_en,
  input  logic [7:0]        ad_data,
  input  logic [7:0]        trig_level,
  input  logic              trig_edge,
  input  logic              trig_mode,
  input  logic [ADDR_W-1:0] pre_len,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [7:0]        buf_wdata,
  output logic              frame_valid,
  output logic [ADDR_W-1:0] frame_start,
  input  logic              frame_ack,
  output logic              triggered,
  output logic [2:0]        state_o
);

  localparam int                AUTO_W    = $clog2(AUTO_TO + 1);
  localparam logic [ADDR_W-1:0] PRE_MAX   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [AUTO_W-1:0] AUTO_LIM  = AUTO_W'(AUTO_TO);
  localparam logic [AUTO_W-1:0] AUTO_ONE  = AUTO_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  osc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d, pre_q, pre_d, tptr_q, tptr_d;
  logic [ADDR_W-1:0] fstart_q, fstart_d, waddr_q, waddr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [AUTO_W-1:0] auto_q, auto_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d, fv_q, fv_d, trig_q, trig_d;

  logic              w_armed_like;
  logic              w_take;
  logic              w_hit;
  logic [ADDR_W:0]   w_cnt_inc;
  logic [ADDR_W:0]   w_post_len;
  logic [AUTO_W-1:0] w_auto_inc;

  // FILL with an empty pre-trigger window behaves as ARMED so no strobe is lost
  assign w_armed_like = (state_q == ST_ARMED) || ((state_q == ST_FILL) && (pre_q == '0));
  assign w_take       = sample_en && run;
  assign w_cnt_inc    = cnt_q + CNT_ONE;
  assign w_auto_inc   = auto_q + AUTO_ONE;
  assign w_post_len   = {1'b0, PRE_MAX} - {1'b0, pre_q};

  osc_edge_det u_edge_det (
    .clk_50M  (clk_50M),
    .rst_n    (rst_n),
    .enable_i (w_armed_like && run),
    .sample_i (w_take && w_armed_like),
    .data_i   (ad_data),
    .level_i  (trig_level),
    .edge_i   (trig_edge),
    .hit_o    (w_hit)
  );

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    pre_d    = pre_q;
    tptr_d   = tptr_q;
    fstart_d = fstart_q;
    cnt_d    = cnt_q;
    auto_d   = auto_q;
    trig_d   = trig_q;
    fv_d     = fv_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    if (!run) begin
      state_d = ST_IDLE;
      fv_d    = 1'b0;
      wptr_d  = '0;
      cnt_d   = '0;
      auto_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // pre_len is ADDR_W wide, so it is already bounded by DEPTH-1
          state_d = ST_FILL;
          pre_d   = pre_len;
          wptr_d  = '0;
          cnt_d   = '0;
          auto_d  = '0;
        end
        ST_FILL, ST_ARMED, ST_POST: begin
          if (w_take) begin
            we_d    = 1'b1;
            waddr_d = wptr_q;
            wdata_d = ad_data;
            wptr_d  = wptr_q + PTR_ONE;
            if (w_armed_like) begin
              if (auto_q < AUTO_LIM) auto_d = w_auto_inc;
              if (w_hit || ((trig_mode == TRIG_AUTO) && (w_auto_inc >= AUTO_LIM))) begin
                tptr_d = wptr_q;
                trig_d = w_hit;
                cnt_d  = '0;
                if (pre_q == PRE_MAX) begin
                  state_d  = ST_DONE;
                  fv_d     = 1'b1;
                  fstart_d = wptr_q - pre_q;
                end else begin
                  state_d = ST_POST;
                end
              end else begin
                state_d = ST_ARMED;
              end
            end else if (state_q == ST_FILL) begin
              cnt_d = w_cnt_inc;
              if (w_cnt_inc == {1'b0, pre_q}) state_d = ST_ARMED;
            end else begin
              cnt_d = w_cnt_inc;
              if (w_cnt_inc == w_post_len) begin
                state_d  = ST_DONE;
                fv_d     = 1'b1;
                fstart_d = tptr_q - pre_q;
              end
            end
          end else if (w_armed_like) begin
            state_d = ST_ARMED;
          end
        end
        ST_DONE: begin
          if (frame_ack) begin
            fv_d    = 1'b0;
            state_d = ST_FILL;
            pre_d   = pre_len;
            wptr_d  = '0;
            cnt_d   = '0;
            auto_d  = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wptr_q   <= '0;
      pre_q    <= '0;
      tptr_q   <= '0;
      fstart_q <= '0;
      cnt_q    <= '0;
      auto_q   <= '0;
      trig_q   <= 1'b0;
      fv_q     <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      pre_q    <= pre_d;
      tptr_q   <= tptr_d;
      fstart_q <= fstart_d;
      cnt_q    <= cnt_d;
      auto_q   <= auto_d;
      trig_q   <= trig_d;
      fv_q     <= fv_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign buf_we      = we_q;
  assign buf_waddr   = waddr_q;
  assign buf_wdata   = wdata_q;
  assign frame_valid = fv_q;
  assign frame_start = fstart_q;
  assign triggered   = trig_q;
  assign state_o     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_osc_trig_ctrl.sv
`default_nettype none
// ============================================================================
// tb_osc_trig_ctrl : scoreboard bench with a sample-count reference model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_osc_trig_ctrl;
  import osc_pkg::*;

  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 16;
  localparam int AUTO_TO = 32;

  logic              clk_50M = 1'b0;
  logic              rst_n = 1'b0, run = 1'b0, sample_en = 1'b0, frame_ack = 1'b0;
  logic              trig_edge = 1'b0, trig_mode = 1'b1;
  logic [7:0]        ad_data = '0, trig_level = '0;
  logic [ADDR_W-1:0] pre_len = '0;
  logic              buf_we, frame_valid, triggered;
  logic [ADDR_W-1:0] buf_waddr, frame_start;
  logic [7:0]        buf_wdata;
  logic [2:0]        state_o;

  osc_trig_ctrl #(.ADDR_W(ADDR_W), .AUTO_TO(AUTO_TO)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .run(run), .sample_en(sample_en),
    .ad_data(ad_data), .trig_level(trig_level), .trig_edge(trig_edge),
    .trig_mode(trig_mode), .pre_len(pre_len), .buf_we(buf_we),
    .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .frame_valid(frame_valid),
    .frame_start(frame_start), .frame_ack(frame_ack), .triggered(triggered),
    .state_o(state_o)
  );

  always #10 clk_50M = ~clk_50M;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int addr; int data; } wr_t;
  wr_t wq[$];
  int  fq_start[$];
  int  fq_trig[$];

  // Reference model: tracks the capture purely by sample counts
  int m_phase;   // 0 pre-fill, 1 waiting for trigger, 2 post-fill, 3 frame done, 4 stopped
  int m_pre, m_addr, m_nfill, m_narmed, m_postleft, m_T, m_prev, m_trig;
  bit m_have_prev;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_start(input int pre);
    m_pre = pre; m_addr = 0; m_nfill = 0; m_narmed = 0; m_have_prev = 0;
    m_phase = (pre == 0) ? 1 : 0;
  endfunction

  function automatic void model_finish(input int trig);
    fq_start.push_back((m_T - m_pre + DEPTH) % DEPTH);
    fq_trig.push_back(trig);
    m_phase = 3;
  endfunction

  function automatic void model_sample(input int d);
    bit hit;
    int lvl;
    wr_t w;
    if (m_phase > 2) return;
    w.addr = m_addr; w.data = d;
    wq.push_back(w);
    lvl = int'(trig_level);
    case (m_phase)
      0: begin
        m_nfill++;
        if (m_nfill == m_pre) m_phase = 1;
      end
      1: begin
        m_narmed++;
        if (trig_edge == EDGE_RISE) hit = m_have_prev && (m_prev < lvl) && (d >= lvl);
        else                        hit = m_have_prev && (m_prev >= lvl) && (d < lvl);
        m_prev = d; m_have_prev = 1;
        if (hit || (trig_mode == TRIG_AUTO && m_narmed >= AUTO_TO)) begin
          m_T = m_addr; m_trig = hit ? 1 : 0;
          m_postleft = DEPTH - 1 - m_pre;
          if (m_postleft == 0) model_finish(m_trig);
          else m_phase = 2;
        end
      end
      default: begin
        m_postleft--;
        if (m_postleft == 0) model_finish(m_trig);
      end
    endcase
    m_addr = (m_addr + 1) % DEPTH;
  endfunction

  task automatic tick();
    @(posedge clk_50M); #1;
  endtask

  task automatic strobe(input int d, input int gap);
    ad_data = 8'(d);
    sample_en = 1'b1;
    if (run) model_sample(d);
    tick();
    sample_en = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic start_capture(input int pre, input int lvl, input logic edg, input logic mode);
    pre_len = ADDR_W'(pre); trig_level = 8'(lvl); trig_edge = edg; trig_mode = mode;
    run = 1'b1;
    model_start(pre);
    tick();
  endtask

  task automatic stop_capture();
    run = 1'b0;
    m_phase = 4;
    tick();
    check("stop_state", int'(state_o), int'(ST_IDLE));
    check("stop_fv", int'(frame_valid), 0);
    repeat (2) tick();
  endtask

  task automatic wait_frame(input string name);
    int k = 0;
    while (!frame_valid && k < 20) begin
      @(negedge clk_50M);
      k++;
    end
    check(name, int'(frame_valid), 1);
  endtask

  // Monitor: every write and every new frame is matched against the model queues
  logic fv_prev = 1'b0;
  wr_t  mon_e;
  always @(negedge clk_50M) begin
    if (rst_n && buf_we) begin
      if (wq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_write: addr %0d data %0d, expected no write", buf_waddr, buf_wdata);
      end else begin
        mon_e = wq.pop_front();
        check("wr_addr", int'(buf_waddr), mon_e.addr);
        check("wr_data", int'(buf_wdata), mon_e.data);
      end
    end
    if (frame_valid && !fv_prev) begin
      if (fq_start.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_frame: start %0d, expected no frame", frame_start);
      end else begin
        check("frame_start", int'(frame_start), fq_start.pop_front());
        check("frame_trig", int'(triggered), fq_trig.pop_front());
      end
    end
    fv_prev <= frame_valid;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, n;
    m_phase = 4;
    repeat (3) tick();
    check("rst_we", int'(buf_we), 0);
    check("rst_waddr", int'(buf_waddr), 0);
    check("rst_wdata", int'(buf_wdata), 0);
    check("rst_fv", int'(frame_valid), 0);
    check("rst_fstart", int'(frame_start), 0);
    check("rst_trig", int'(triggered), 0);
    check("rst_state", int'(state_o), int'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // Ramp, rising edge at 100, pre 4: hit on 104 at addr 13, frame starts at 9
    start_capture(4, 100, EDGE_RISE, TRIG_NORMAL);
    check("t1_state_fill", int'(state_o), int'(ST_FILL));
    v = 0;
    while (m_phase < 3 && v < 256) begin strobe(v, $urandom_range(0, 2)); v += 8; end
    wait_frame("t1_frame");
    check("t1_fstart_abs", int'(frame_start), 9);
    check("t1_triggered", int'(triggered), 1);
    check("t1_state_done", int'(state_o), int'(ST_DONE));

    // Strobes in DONE are ignored; ack returns to FILL with the new config
    for (int i = 0; i < 4; i++) strobe(200 + i, 0);
    pre_len = 4'd4; trig_mode = TRIG_AUTO; trig_level = 8'd100; trig_edge = EDGE_RISE;
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check("t6_fv_after_ack", int'(frame_valid), 0);
    check("t6_state_fill", int'(state_o), int'(ST_FILL));
    model_start(4);

    // Constant 50 in auto mode: timeout on 32nd armed strobe at addr 3
    n = 0;
    while (m_phase < 3 && n < 100) begin strobe(50, $urandom_range(0, 1)); n++; end
    check("t2_strobes", n, 4 + AUTO_TO + 11);
    wait_frame("t2_frame");
    check("t2_triggered", int'(triggered), 0);
    check("t2_fstart_abs", int'(frame_start), 15);
    stop_capture();

    // Constant 50 in normal mode: never triggers, writes keep wrapping
    start_capture(4, 100, EDGE_RISE, TRIG_NORMAL);
    for (int i = 0; i < 200; i++) strobe(50, 0);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check("t3_state_armed", int'(state_o), int'(ST_ARMED));
    check("t3_fv", int'(frame_valid), 0);
    stop_capture();

    // Falling edge with the full pre-trigger window: DONE right after the hit
    start_capture(15, 100, EDGE_FALL, TRIG_NORMAL);
    for (int i = 0; i < 16; i++) strobe(120, $urandom_range(0, 2));
    strobe(80, 0);
    check("t4_state_done", int'(state_o), int'(ST_DONE));
    check("t4_fstart_abs", int'(frame_start), 1);
    check("t4_triggered", int'(triggered), 1);
    stop_capture();

    // run dropped mid-POST together with a strobe: the strobe is lost
    start_capture(4, 100, EDGE_RISE, TRIG_NORMAL);
    v = 0;
    while (!(m_phase == 2 && m_postleft <= 5) && v < 256) begin strobe(v, 1); v += 8; end
    check("t5_state_post", int'(state_o), int'(ST_POST));
    ad_data = 8'd77; sample_en = 1'b1; run = 1'b0; m_phase = 4;
    tick();
    sample_en = 1'b0;
    check("t5_state_idle", int'(state_o), int'(ST_IDLE));
    check("t5_we_low", int'(buf_we), 0);
    repeat (2) tick();
    check("t5_no_pending", wq.size(), 0);
    start_capture(4, 100, EDGE_RISE, TRIG_NORMAL);
    v = 0;
    while (m_phase < 3 && v < 256) begin strobe(v, 0); v += 8; end
    wait_frame("t5_frame");
    stop_capture();

    // Randomised captures
    for (int c = 0; c < 10; c++) begin
      start_capture($urandom_range(0, 15), $urandom_range(40, 215),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n = 0;
      while (m_phase < 3 && n < 150) begin
        strobe($urandom_range(0, 255), $urandom_range(0, 2));
        n++;
      end
      if (m_phase == 3) begin
        wait_frame("rnd_frame");
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check("rnd_ack_fv", int'(frame_valid), 0);
      end
      stop_capture();
    end

    repeat (3) tick();
    check("wq_drained", wq.size(), 0);
    check("fq_drained", fq_start.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
